// File: rtl/mfu_pkg.sv
// Shared constants and types for the fusion-unit accumulator readout path:
// precision modes, per-mode lane geometry and the drain FSM state encoding.
package mfu_pkg;

  localparam int SUM_W      = 128;
  localparam int LANE_IDX_W = 4;

  localparam logic [1:0] MODE_2B  = 2'b00;
  localparam logic [1:0] MODE_4B  = 2'b01;
  localparam logic [1:0] MODE_8B  = 2'b10;
  localparam logic [1:0] MODE_INV = 2'b11;

  localparam int LANE_W_2B = 8;
  localparam int LANE_W_4B = 12;
  localparam int LANE_W_8B = 20;

  localparam int LANES_2B = 16;
  localparam int LANES_4B = 4;
  localparam int LANES_8B = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Index of the final lane for a given precision mode.
  function automatic logic [LANE_IDX_W-1:0] last_lane(input logic [1:0] mode);
    logic [LANE_IDX_W-1:0] idx;
    idx = '0;
    case (mode)
      MODE_2B: idx = LANE_IDX_W'(LANES_2B - 1);
      MODE_4B: idx = LANE_IDX_W'(LANES_4B - 1);
      default: idx = LANE_IDX_W'(LANES_8B - 1);
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/mfu_drain_if.sv
// Capture and output-stream signals of the accumulator drain stage.
// cap_relu exists only when MFU_DRAIN_RELU_EN is defined.
interface mfu_drain_if
  import mfu_pkg::*;
#(
  parameter int OUT_W = 32
);

  logic                  cap_valid;
  logic                  cap_ready;
  logic [SUM_W-1:0]      cap_sum;
  logic [1:0]            cap_mode;
  logic                  cap_signed;
`ifdef MFU_DRAIN_RELU_EN
  logic                  cap_relu;
`endif
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_data;
  logic [LANE_IDX_W-1:0] out_lane;
  logic                  out_last;
  logic                  err_mode;

  // Drain stage view: accepts captures, produces the lane stream.
  modport master (
    input  cap_valid,
    input  cap_sum,
    input  cap_mode,
    input  cap_signed,
`ifdef MFU_DRAIN_RELU_EN
    input  cap_relu,
`endif
    input  out_ready,
    output cap_ready,
    output out_valid,
    output out_data,
    output out_lane,
    output out_last,
    output err_mode
  );

  // Environment view: issues captures, consumes the lane stream.
  modport slave (
    output cap_valid,
    output cap_sum,
    output cap_mode,
    output cap_signed,
`ifdef MFU_DRAIN_RELU_EN
    output cap_relu,
`endif
    output out_ready,
    input  cap_ready,
    input  out_valid,
    input  out_data,
    input  out_lane,
    input  out_last,
    input  err_mode
  );

endinterface

// File: rtl/mfu_lane_extract.sv
// Combinational lane selector: picks one lane of the packed accumulator
// according to the precision mode and sign- or zero-extends it to OUT_W.
module mfu_lane_extract
  import mfu_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic [SUM_W-1:0]      sum,
  input  logic [1:0]            mode,
  input  logic [LANE_IDX_W-1:0] lane,
  input  logic                  sgn,
  output logic [OUT_W-1:0]      word
);

  logic [6:0]           idx8;
  logic [6:0]           idx12;
  logic [LANE_W_2B-1:0] lane8;
  logic [LANE_W_4B-1:0] lane12;
  logic [LANE_W_8B-1:0] lane20;
  logic                 ext8;
  logic                 ext12;
  logic                 ext20;

  always_comb begin
    idx8   = {lane, 3'b000};
    idx12  = 7'(lane[1:0]) * 7'd12;
    lane8  = sum[idx8 +: LANE_W_2B];
    lane12 = sum[idx12 +: LANE_W_4B];
    lane20 = sum[LANE_W_8B-1:0];
    // Fill bit is the lane MSB for signed lanes, zero otherwise.
    ext8   = sgn & lane8[LANE_W_2B-1];
    ext12  = sgn & lane12[LANE_W_4B-1];
    ext20  = sgn & lane20[LANE_W_8B-1];
    word   = '0;
    case (mode)
      MODE_2B: word = {{(OUT_W - LANE_W_2B){ext8}},  lane8};
      MODE_4B: word = {{(OUT_W - LANE_W_4B){ext12}}, lane12};
      MODE_8B: word = {{(OUT_W - LANE_W_8B){ext20}}, lane20};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/mfu_drain.sv
// Accumulator readout: snapshots the packed sum and streams extended lanes
// one per handshake. Optional ReLU clamp is built when MFU_DRAIN_RELU_EN is defined.
module mfu_drain
  import mfu_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  mfu_drain_if.master bus
);

  state_e                state;

  // Capture snapshot (data only, never reset)
  logic [SUM_W-1:0]      sum_p0;
  logic [1:0]            mode_p0;
  logic                  sgn_p0;
`ifdef MFU_DRAIN_RELU_EN
  logic                  relu_p0;
  logic                  ext_relu;
`endif

  // Registered output stage
  logic                  out_valid_p1;
  logic [OUT_W-1:0]      out_data_p1;
  logic [LANE_IDX_W-1:0] out_lane_p1;
  logic                  out_last_p1;
  logic                  err_mode_p1;

  logic                  cap_fire;
  logic                  out_fire;
  logic [SUM_W-1:0]      ext_sum;
  logic [1:0]            ext_mode;
  logic [LANE_IDX_W-1:0] ext_lane;
  logic                  ext_sgn;
  logic [OUT_W-1:0]      ext_word;
  logic [OUT_W-1:0]      next_word;

`ifdef MFU_DRAIN_RELU_EN
  // A signed lane is already sign-extended, so its MSB sits in the top bit.
  function automatic logic [OUT_W-1:0] relu_clamp(input logic [OUT_W-1:0] w,
                                                  input logic             sgn,
                                                  input logic             relu);
    if (relu && sgn && w[OUT_W-1]) return '0;
    return w;
  endfunction
`endif

  assign bus.cap_ready = (state == ST_IDLE);
  assign bus.out_valid = out_valid_p1;
  assign bus.out_data  = out_data_p1;
  assign bus.out_lane  = out_lane_p1;
  assign bus.out_last  = out_last_p1;
  assign bus.err_mode  = err_mode_p1;

  always_comb begin
    cap_fire = bus.cap_valid && (state == ST_IDLE);
    out_fire = out_valid_p1 && bus.out_ready;
  end

  // The next word is computed ahead of time so every output stays registered:
  // lane 0 straight from the live capture bus, later lanes from the snapshot.
  always_comb begin
    ext_sum  = sum_p0;
    ext_mode = mode_p0;
    ext_sgn  = sgn_p0;
    ext_lane = out_lane_p1 + LANE_IDX_W'(1);
`ifdef MFU_DRAIN_RELU_EN
    ext_relu = relu_p0;
`endif
    if (state == ST_IDLE) begin
      ext_sum  = bus.cap_sum;
      ext_mode = bus.cap_mode;
      ext_sgn  = bus.cap_signed;
      ext_lane = '0;
`ifdef MFU_DRAIN_RELU_EN
      ext_relu = bus.cap_relu;
`endif
    end
  end

  mfu_lane_extract #(
    .OUT_W (OUT_W)
  ) u_extract (
    .sum  (ext_sum),
    .mode (ext_mode),
    .lane (ext_lane),
    .sgn  (ext_sgn),
    .word (ext_word)
  );

`ifdef MFU_DRAIN_RELU_EN
  assign next_word = relu_clamp(ext_word, ext_sgn, ext_relu);
`else
  assign next_word = ext_word;
`endif

  // Stage p0: snapshot capture
  always_ff @(posedge clk) begin
    if (cap_fire && (bus.cap_mode != MODE_INV)) begin
      sum_p0  <= bus.cap_sum;
      mode_p0 <= bus.cap_mode;
      sgn_p0  <= bus.cap_signed;
`ifdef MFU_DRAIN_RELU_EN
      relu_p0 <= bus.cap_relu;
`endif
    end
  end

  // Stage p1: FSM, lane counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      out_valid_p1 <= 1'b0;
      out_data_p1  <= '0;
      out_lane_p1  <= '0;
      out_last_p1  <= 1'b0;
      err_mode_p1  <= 1'b0;
    end else begin
      err_mode_p1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cap_fire) begin
            if (bus.cap_mode == MODE_INV) begin
              err_mode_p1 <= 1'b1;
            end else begin
              state        <= ST_DRAIN;
              out_valid_p1 <= 1'b1;
              out_data_p1  <= next_word;
              out_lane_p1  <= '0;
              out_last_p1  <= (last_lane(bus.cap_mode) == '0);
            end
          end
        end
        ST_DRAIN: begin
          if (out_fire) begin
            if (out_last_p1) begin
              state        <= ST_IDLE;
              out_valid_p1 <= 1'b0;
              out_last_p1  <= 1'b0;
            end else begin
              out_data_p1 <= next_word;
              out_lane_p1 <= ext_lane;
              out_last_p1 <= (ext_lane == last_lane(mode_p0));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mfu_drain.sv
// Scoreboard bench for mfu_drain: directed captures push expected lane words,
// a negedge monitor pops and compares on every output handshake.
module tb_mfu_drain;
  import mfu_pkg::*;

  localparam int OUT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mfu_drain_if #(.OUT_W(OUT_W)) bus ();

  mfu_drain #(.OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [3:0]       lane;
    logic             last;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int n_pass  = 0;
  int n_total = 0;
  int n_words = 0;

  logic             stall_prev = 1'b0;
  logic [OUT_W-1:0] data_prev;
  logic [3:0]       lane_prev;
  logic             last_prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [OUT_W-1:0] d, input logic [3:0] l, input logic last);
    exp_t x;
    x.data = d;
    x.lane = l;
    x.last = last;
    exp_q.push_back(x);
  endtask

  task automatic capture(input logic [127:0] sum, input logic [1:0] mode,
                         input logic sgn, input string tag);
    int n = 0;
    bus.cap_sum    = sum;
    bus.cap_mode   = mode;
    bus.cap_signed = sgn;
    bus.cap_valid  = 1'b1;
    while (!bus.cap_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      n_total++;
      $display("FAIL %s_cap_timeout: cap_ready low for %0d cycles, required high", tag, n);
    end
    step();
    bus.cap_valid = 1'b0;
    if (mode != MODE_INV) chk({tag, "_latency_valid"}, 64'(bus.out_valid), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || !bus.cap_ready) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      n_total++;
      $display("FAIL %s_drain_timeout: %0d words outstanding, required 0", tag, exp_q.size());
    end else begin
      chk({tag, "_done_valid"}, 64'(bus.out_valid), 64'd0);
    end
  endtask

  // Monitor: compare every accepted word, and check stability across stalls.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("bp_valid_hold", 64'(bus.out_valid), 64'd1);
        chk("bp_data_stable", 64'(bus.out_data), 64'(data_prev));
        chk("bp_lane_stable", 64'(bus.out_lane), 64'(lane_prev));
        chk("bp_last_stable", 64'(bus.out_last), 64'(last_prev));
      end
      if (bus.out_valid && bus.out_ready) begin
        n_words++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_word: got lane %0d data %0h, required no word",
                   bus.out_lane, bus.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", 64'(bus.out_data), 64'(e.data));
          chk("word_lane", 64'(bus.out_lane), 64'(e.lane));
          chk("word_last", 64'(bus.out_last), 64'(e.last));
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      data_prev  = bus.out_data;
      lane_prev  = bus.out_lane;
      last_prev  = bus.out_last;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] s;
    int n;
    int w0;

    bus.cap_valid  = 1'b0;
    bus.cap_sum    = '0;
    bus.cap_mode   = MODE_2B;
    bus.cap_signed = 1'b0;
    bus.out_ready  = 1'b1;
`ifdef MFU_DRAIN_RELU_EN
    bus.cap_relu   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data",  64'(bus.out_data),  64'd0);
    chk("rst_out_lane",  64'(bus.out_lane),  64'd0);
    chk("rst_out_last",  64'(bus.out_last),  64'd0);
    chk("rst_err_mode",  64'(bus.err_mode),  64'd0);
    chk("rst_cap_ready", 64'(bus.cap_ready), 64'd1);

    // 8bx8b signed, then unsigned with MSB set
    push(32'hFFFFFF38, 4'd0, 1'b1);
    capture({108'h0, 20'hFFF38}, MODE_8B, 1'b1, "t1");
    wait_idle("t1");
    push(32'h00080001, 4'd0, 1'b1);
    capture({108'h0, 20'h80001}, MODE_8B, 1'b0, "t1b");
    wait_idle("t1b");

    // 4bx4b signed; live cap_sum changes during drain must not matter
    push(32'hFFFFFFFF, 4'd0, 1'b0);
    push(32'h00000001, 4'd1, 1'b0);
    push(32'h000007FF, 4'd2, 1'b0);
    push(32'hFFFFF800, 4'd3, 1'b1);
    capture({80'h0, 48'h800_7FF_001_FFF}, MODE_4B, 1'b1, "t2");
    bus.cap_sum = '1;
    wait_idle("t2");

    // 2bx2b unsigned, all lanes F0; cap_ready returns one cycle after lane 15
    for (int k = 0; k < 16; k++) push(32'h000000F0, 4'(k), k == 15);
    capture({16{8'hF0}}, MODE_2B, 1'b0, "t3");
    n = 0;
    while (exp_q.size() > 1 && n < 100) begin
      step();
      n++;
    end
    chk("t3_busy_ready", 64'(bus.cap_ready), 64'd0);
    chk("t3_lane15",     64'(bus.out_lane),  64'd15);
    step();
    chk("t3_next_ready", 64'(bus.cap_ready), 64'd1);
    chk("t3_next_valid", 64'(bus.out_valid), 64'd0);
    wait_idle("t3");

    // Backpressure at lane 2 for 3 cycles
    push(32'h00000ABC, 4'd0, 1'b0);
    push(32'h00000789, 4'd1, 1'b0);
    push(32'h00000456, 4'd2, 1'b0);
    push(32'h00000123, 4'd3, 1'b1);
    w0 = n_words;
    capture({80'h0, 48'h123_456_789_ABC}, MODE_4B, 1'b0, "t4");
    n = 0;
    while (bus.out_lane != 4'd2 && n < 50) begin
      step();
      n++;
    end
    bus.out_ready = 1'b0;
    repeat (3) step();
    bus.out_ready = 1'b1;
    wait_idle("t4");
    chk("t4_word_count", 64'(n_words - w0), 64'd4);

    // Invalid mode
    capture({112'h0, 16'hDEAD}, MODE_INV, 1'b1, "t5");
    chk("t5_err_pulse",   64'(bus.err_mode),  64'd1);
    chk("t5_no_valid",    64'(bus.out_valid), 64'd0);
    step();
    chk("t5_err_cleared", 64'(bus.err_mode),  64'd0);
    chk("t5_still_idle",  64'(bus.out_valid), 64'd0);
    chk("t5_ready",       64'(bus.cap_ready), 64'd1);

    // Reset at lane 5 of a 2bx2b drain, then a fresh capture
    s = '0;
    for (int k = 0; k < 16; k++) s[k*8 +: 8] = 8'(8'h80 + k);
    for (int k = 0; k < 5; k++) push(32'hFFFFFF80 + 32'(k), 4'(k), 1'b0);
    capture(s, MODE_2B, 1'b1, "t6");
    n = 0;
    while (bus.out_lane != 4'd5 && n < 50) begin
      step();
      n++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_valid",   64'(bus.out_valid), 64'd0);
    chk("t6_ready",   64'(bus.cap_ready), 64'd1);
    chk("t6_lane",    64'(bus.out_lane),  64'd0);
    chk("t6_data",    64'(bus.out_data),  64'd0);
    chk("t6_last",    64'(bus.out_last),  64'd0);
    chk("t6_pending", 64'(exp_q.size()),  64'd0);
    push(32'h0000000C, 4'd0, 1'b0);
    push(32'h0000000D, 4'd1, 1'b0);
    push(32'h0000000E, 4'd2, 1'b0);
    push(32'h0000000F, 4'd3, 1'b1);
    capture({80'h0, 48'h00F_00E_00D_00C}, MODE_4B, 1'b0, "t6b");
    wait_idle("t6b");

    // Simultaneous reset and capture: reset wins
    bus.cap_sum    = {108'h0, 20'h00001};
    bus.cap_mode   = MODE_8B;
    bus.cap_signed = 1'b0;
    bus.cap_valid  = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.cap_valid = 1'b0;
    chk("t7_valid", 64'(bus.out_valid), 64'd0);
    chk("t7_ready", 64'(bus.cap_ready), 64'd1);
    step();
    chk("t7_valid_after", 64'(bus.out_valid), 64'd0);

`ifdef MFU_DRAIN_RELU_EN
    // ReLU: negative signed lane 3 clamps to zero, positive lanes pass
    bus.cap_relu = 1'b1;
    push(32'h000007FF, 4'd0, 1'b0);
    push(32'h00000045, 4'd1, 1'b0);
    push(32'h00000123, 4'd2, 1'b0);
    push(32'h00000000, 4'd3, 1'b1);
    capture({80'h0, 48'h800_123_045_7FF}, MODE_4B, 1'b1, "t8");
    bus.cap_relu = 1'b0;
    wait_idle("t8");
`endif

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
